// File: rtl/cpu_result_monitor.sv
// Flow-controlled consumer of the cpu result handshake: captures each result, re-checks it
// against a reference ALU model and queues the checked record in a small FIFO.
module cpu_result_monitor #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    result_ready,
  input  logic                    data_out,
  input  logic [7:0]              opcode,
  input  logic signed [7:0]       operand_A_out,
  input  logic signed [7:0]       operand_B_out,
  input  logic signed [7:0]       result_out_cpu,
  input  logic                    carry_out_cpu,
  input  logic                    borrow_out_cpu,
  input  logic [7:0]              pc_out,
  output logic                    next_out,
  input  logic                    rd_en,
  output logic                    rd_valid,
  output logic [7:0]              rd_pc,
  output logic signed [7:0]       rd_result,
  output logic signed [7:0]       rd_expected,
  output logic                    rd_mismatch,
  output logic                    full,
  output logic [CNT_W-1:0]        checked_count,
  output logic [CNT_W-1:0]        error_count,
  output logic [CNT_W-1:0]        drop_count
);

  localparam int DATA_W = 8;
  localparam int AW     = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, CHECK} state_t;

  state_t state, state_nxt;

  logic                     next_out_nxt;
  logic                     capture, drop, push, pop, empty;
  logic [AW:0]              wr_ptr, rd_ptr, count, count_nxt;
  logic [AW-1:0]            rd_idx;

  logic [2:0]               op_p1;
  logic signed [DATA_W-1:0] a_p1, b_p1, res_p1;
  logic                     carry_p1, borrow_p1;
  logic [7:0]               pc_p1;

  logic [DATA_W+1:0]        model;
  logic signed [DATA_W-1:0] exp_res;
  logic                     exp_carry, exp_borrow, mismatch;

  logic [7:0]               pc_mem  [DEPTH];
  logic signed [DATA_W-1:0] res_mem [DEPTH];
  logic signed [DATA_W-1:0] exp_mem [DEPTH];
  logic                     mis_mem [DEPTH];

  logic                     unused_opcode_hi;

  // Reference ALU, returns {carry, borrow, result}
  function automatic logic [DATA_W+1:0] alu_model(input logic [2:0] op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] r;
    logic              c, bw;
    sum = '0;
    r   = '0;
    c   = 1'b0;
    bw  = 1'b0;
    case (op)
      3'd0: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[DATA_W-1:0];
        c   = sum[DATA_W];
      end
      3'd1: begin
        r  = a - b;
        bw = (a < b);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin
        r = {a[DATA_W-2:0], 1'b0};
        c = a[DATA_W-1];
      end
      default: begin
        r  = {1'b0, a[DATA_W-1:1]};
        bw = a[0];
      end
    endcase
    return {c, bw, r};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign unused_opcode_hi = ^opcode[7:3];

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_idx  = rd_ptr[AW-1:0];

  assign capture = (state == REQ) && next_out && result_ready && data_out;
  assign drop    = result_ready && !capture;
  assign pop     = rd_en && !empty;
  assign push    = (state == CHECK) && (!full || pop);

  assign count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_comb begin
    state_nxt    = state;
    next_out_nxt = 1'b0;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ: begin
        if (capture) state_nxt = CHECK;
        next_out_nxt = !capture && (count_nxt != (AW+1)'(DEPTH));
      end
      CHECK:   state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      next_out      <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      checked_count <= '0;
      error_count   <= '0;
      drop_count    <= '0;
    end else begin
      state    <= state_nxt;
      next_out <= next_out_nxt;
      if (push) begin
        wr_ptr        <= wr_ptr + 1'b1;
        checked_count <= sat_inc(checked_count);
        if (mismatch) error_count <= sat_inc(error_count);
      end
      if (pop)  rd_ptr     <= rd_ptr + 1'b1;
      if (drop) drop_count <= sat_inc(drop_count);
    end
  end

  // Stage p1: inputs latched on an accepted strobe
  always_ff @(posedge clk) begin
    if (capture) begin
      op_p1     <= opcode[2:0];
      a_p1      <= operand_A_out;
      b_p1      <= operand_B_out;
      res_p1    <= result_out_cpu;
      carry_p1  <= carry_out_cpu;
      borrow_p1 <= borrow_out_cpu;
      pc_p1     <= pc_out;
    end
  end

  // CHECK stage: compare against the model and write the record
  assign model      = alu_model(op_p1, a_p1, b_p1);
  assign exp_carry  = model[DATA_W+1];
  assign exp_borrow = model[DATA_W];
  assign exp_res    = model[DATA_W-1:0];
  assign mismatch   = (exp_res != res_p1) || (exp_carry != carry_p1) || (exp_borrow != borrow_p1);

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr[AW-1:0]]  <= pc_p1;
      res_mem[wr_ptr[AW-1:0]] <= res_p1;
      exp_mem[wr_ptr[AW-1:0]] <= exp_res;
      mis_mem[wr_ptr[AW-1:0]] <= mismatch;
    end
  end

  assign rd_valid    = !empty;
  assign rd_pc       = rd_valid ? pc_mem[rd_idx]  : '0;
  assign rd_result   = rd_valid ? res_mem[rd_idx] : '0;
  assign rd_expected = rd_valid ? exp_mem[rd_idx] : '0;
  assign rd_mismatch = rd_valid ? mis_mem[rd_idx] : 1'b0;

endmodule

// File: tb/tb_cpu_result_monitor.sv
// Bench for cpu_result_monitor: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the handshake and record queue.
module tb_cpu_result_monitor;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             result_ready = 1'b0, data_out = 1'b0, rd_en = 1'b0;
  logic [7:0]       opcode = '0, op_a = '0, op_b = '0, res_cpu = '0, pc = '0;
  logic             carry_cpu = 1'b0, borrow_cpu = 1'b0;
  logic             next_out, rd_valid, rd_mismatch, full;
  logic [7:0]       rd_pc, rd_result, rd_expected;
  logic [CNT_W-1:0] checked_count, error_count, drop_count;

  cpu_result_monitor #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .result_ready(result_ready), .data_out(data_out),
    .opcode(opcode), .operand_A_out(op_a), .operand_B_out(op_b),
    .result_out_cpu(res_cpu), .carry_out_cpu(carry_cpu), .borrow_out_cpu(borrow_cpu),
    .pc_out(pc), .next_out(next_out), .rd_en(rd_en), .rd_valid(rd_valid),
    .rd_pc(rd_pc), .rd_result(rd_result), .rd_expected(rd_expected),
    .rd_mismatch(rd_mismatch), .full(full), .checked_count(checked_count),
    .error_count(error_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pc, res, expv;
    logic       mis, ec, eb;
  } rec_t;

  rec_t q[$];
  rec_t pend;
  bit   pend_v, m_next_out, m_idle;
  int   m_chk, m_err, m_drop;
  int   checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t ref_rec(input logic [7:0] op, a, b, res, p, input logic c, bw);
    int   ua = a, ub = b, r = 0;
    rec_t t;
    t.ec = 0;
    t.eb = 0;
    case (op & 8'd7)
      0: begin r = ua + ub; t.ec = (r > 255); end
      1: begin r = ua - ub; t.eb = (ua < ub); end
      2: r = ua & ub;
      3: r = ua | ub;
      4: r = ua ^ ub;
      5: r = ~ua;
      6: begin r = ua * 2; t.ec = a[7]; end
      default: begin r = ua / 2; t.eb = a[0]; end
    endcase
    t.expv = r[7:0];
    t.pc   = p;
    t.res  = res;
    t.mis  = (res != t.expv) || (c != t.ec) || (bw != t.eb);
    return t;
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic step(input bit r, input bit rr, input bit dv, input bit re);
    bit   cap;
    rec_t h;
    rst = r; result_ready = rr; data_out = dv; rd_en = re;
    if (r) begin
      q.delete();
      pend_v = 0; m_next_out = 0; m_idle = 1;
      m_chk = 0; m_err = 0; m_drop = 0;
    end else begin
      cap = m_next_out && rr && dv;
      if (rr && !cap) m_drop = sat(m_drop);
      if (re && q.size() > 0) void'(q.pop_front());
      if (pend_v) begin
        q.push_back(pend);
        m_chk = sat(m_chk);
        if (pend.mis) m_err = sat(m_err);
        pend_v = 0;
        m_next_out = 0;
      end else if (m_idle) begin
        m_idle = 0;
        m_next_out = 0;
      end else if (cap) begin
        pend = ref_rec(opcode, op_a, op_b, res_cpu, pc, carry_cpu, borrow_cpu);
        pend_v = 1;
        m_next_out = 0;
      end else begin
        m_next_out = (q.size() < DEPTH);
      end
    end
    @(posedge clk);
    #1;
    rst = 0; result_ready = 0; data_out = 0; rd_en = 0;
    h = '{pc: 8'h0, res: 8'h0, expv: 8'h0, mis: 1'b0, ec: 1'b0, eb: 1'b0};
    if (q.size() > 0) h = q[0];
    check("next_out", next_out, m_next_out);
    check("rd_valid", rd_valid, q.size() > 0);
    check("full", full, q.size() == DEPTH);
    check("rd_pc", rd_pc, h.pc);
    check("rd_result", rd_result, h.res);
    check("rd_expected", rd_expected, h.expv);
    check("rd_mismatch", rd_mismatch, h.mis);
    check("checked_count", checked_count, m_chk);
    check("error_count", error_count, m_err);
    check("drop_count", drop_count, m_drop);
  endtask

  task automatic set_fields(input logic [7:0] op, a, b, res, p, input logic c, bw);
    opcode = op; op_a = a; op_b = b; res_cpu = res; pc = p; carry_cpu = c; borrow_cpu = bw;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 12 && !m_next_out; i++) step(0, 0, 0, 0);
    check("req_ready", next_out, 1);
  endtask

  task automatic send();
    wait_req();
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
  endtask

  initial begin
    // reset, then next_out rises two cycles after rst falls
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    check("rst_next_out", next_out, 0);
    check("rst_checked", checked_count, 0);
    step(0, 0, 0, 0);
    check("next_out_1cyc", next_out, 0);
    step(0, 0, 0, 0);
    check("next_out_2cyc", next_out, 1);

    // ADD, correct result
    set_fields(8'h00, 8'd100, 8'd27, 8'd127, 8'h10, 0, 0);
    step(0, 1, 1, 0);
    check("add_lat1", rd_valid, 0);
    step(0, 0, 0, 0);
    check("add_lat2", rd_valid, 1);
    check("add_exp", rd_expected, 8'd127);
    check("add_mis", rd_mismatch, 0);
    check("add_cnt", checked_count, 1);
    step(0, 0, 0, 1);

    // SUB with missing borrow
    set_fields(8'h01, 8'd5, 8'd10, 8'hFB, 8'h11, 0, 0);
    send();
    check("sub_exp", rd_expected, 8'hFB);
    check("sub_mis", rd_mismatch, 1);
    check("sub_err", error_count, 1);
    step(0, 0, 0, 1);

    // signed overflow wraps
    set_fields(8'h00, 8'd127, 8'd1, 8'h80, 8'h12, 0, 0);
    send();
    check("ovf_exp", rd_expected, 8'h80);
    check("ovf_mis", rd_mismatch, 0);
    step(0, 0, 0, 1);

    // backpressure: fill, drop one, pop one, drain
    for (int i = 0; i < DEPTH; i++) begin
      set_fields(8'(i), 8'($urandom), 8'($urandom), 8'($urandom), 8'(8'h20 + i), 0, 0);
      send();
    end
    step(0, 0, 0, 0);
    check("bp_full", full, 1);
    check("bp_next_out", next_out, 0);
    step(0, 1, 1, 0);
    check("bp_drop", drop_count, 1);
    step(0, 0, 0, 1);
    check("bp_resume", next_out, 1);
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) step(0, 0, 0, 1);

    // reset in the CHECK cycle discards the record
    set_fields(8'h02, 8'hF0, 8'h3C, 8'h30, 8'h40, 0, 0);
    wait_req();
    step(0, 1, 1, 0);
    step(1, 0, 0, 0);
    check("midrst_valid", rd_valid, 0);
    check("midrst_checked", checked_count, 0);
    check("midrst_err", error_count, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rec_t t;
      set_fields(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        t = ref_rec(opcode, op_a, op_b, res_cpu, pc, carry_cpu, borrow_cpu);
        res_cpu = t.expv; carry_cpu = t.ec; borrow_cpu = t.eb;
      end
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
